// File: rtl/id_ex_reg_pkg.sv
// Shared constants and types for the ID/EX pipeline register.
// Holds the ALU op codes, the reset PC and the registered-field layout.
package id_ex_reg_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h0000_3000;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluOri = 3'd2;
  localparam logic [2:0] AluLui = 3'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] ext_imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  wa;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
    logic        regwrite;
    logic        memwrite;
    logic        memtoreg;
    logic [1:0]  tnew;
    logic        valid;
  } id_ex_t;

  // One stage has elapsed since ID, so the remaining Tnew drops by one, floored at 0.
  function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/id_ex_reg_fwd_mux.sv
// Operand forwarding select: M-stage result, then W-stage write data, then the registered value.
// Register 0 is hard-wired and never takes a forwarded value.
module id_ex_reg_fwd_mux (
  input  logic [4:0]  addr_i,
  input  logic [31:0] reg_data_i,
  input  logic        m_we_i,
  input  logic [4:0]  m_addr_i,
  input  logic [31:0] m_data_i,
  input  logic        w_we_i,
  input  logic [4:0]  w_addr_i,
  input  logic [31:0] w_data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = reg_data_i;
    if (addr_i != 5'd0 && m_we_i && m_addr_i == addr_i) begin
      data_o = m_data_i;
    end else if (addr_i != 5'd0 && w_we_i && w_addr_i == addr_i) begin
      data_o = w_data_i;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded ID state, inserts bubbles on stall,
// and drives forwarded ALU operands and store data into EX.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] D_pc,
  input  logic [31:0] D_rs_data,
  input  logic [31:0] D_rt_data,
  input  logic [31:0] D_ext_imm,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [4:0]  D_wa,
  input  logic [2:0]  D_ALUCtrl,
  input  logic        D_ALUSrc,
  input  logic        D_regwrite,
  input  logic        D_memwrite,
  input  logic        D_memtoreg,
  input  logic [1:0]  D_tnew,
  input  logic        M_fwd_we,
  input  logic [4:0]  M_fwd_addr,
  input  logic [31:0] M_fwd_data,
  input  logic        W_fwd_we,
  input  logic [4:0]  W_fwd_addr,
  input  logic [31:0] W_fwd_data,
  output logic [31:0] E_pc,
  output logic [31:0] E_alu_A,
  output logic [31:0] E_alu_B,
  output logic [31:0] E_rt_fwd,
  output logic [2:0]  E_ALUCtrl,
  output logic [4:0]  E_wa,
  output logic        E_regwrite,
  output logic        E_memwrite,
  output logic        E_memtoreg,
  output logic [4:0]  E_rs_addr,
  output logic [4:0]  E_rt_addr,
  output logic [1:0]  E_tnew,
  output logic        E_valid
);

  id_ex_t ex_d, ex_q, reset_val;
  logic [31:0] rs_fwd, rt_fwd;

  always_comb begin
    reset_val    = '0;
    reset_val.pc = RESET_PC;
  end

  // A bubble keeps only the PC; zeroed addresses guarantee it never matches a forward.
  always_comb begin
    ex_d    = '0;
    ex_d.pc = D_pc;
    if (!stall) begin
      ex_d.rs_data  = D_rs_data;
      ex_d.rt_data  = D_rt_data;
      ex_d.ext_imm  = D_ext_imm;
      ex_d.rs_addr  = D_rs_addr;
      ex_d.rt_addr  = D_rt_addr;
      ex_d.wa       = D_wa;
      ex_d.alu_ctrl = D_ALUCtrl;
      ex_d.alu_src  = D_ALUSrc;
      ex_d.regwrite = D_regwrite;
      ex_d.memwrite = D_memwrite;
      ex_d.memtoreg = D_memtoreg;
      ex_d.tnew     = D_tnew;
      ex_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= reset_val;
    end else begin
      ex_q <= ex_d;
    end
  end

  id_ex_reg_fwd_mux u_fwd_rs (
    .addr_i     (ex_q.rs_addr),
    .reg_data_i (ex_q.rs_data),
    .m_we_i     (M_fwd_we),
    .m_addr_i   (M_fwd_addr),
    .m_data_i   (M_fwd_data),
    .w_we_i     (W_fwd_we),
    .w_addr_i   (W_fwd_addr),
    .w_data_i   (W_fwd_data),
    .data_o     (rs_fwd)
  );

  id_ex_reg_fwd_mux u_fwd_rt (
    .addr_i     (ex_q.rt_addr),
    .reg_data_i (ex_q.rt_data),
    .m_we_i     (M_fwd_we),
    .m_addr_i   (M_fwd_addr),
    .m_data_i   (M_fwd_data),
    .w_we_i     (W_fwd_we),
    .w_addr_i   (W_fwd_addr),
    .w_data_i   (W_fwd_data),
    .data_o     (rt_fwd)
  );

  always_comb begin
    E_pc       = ex_q.pc;
    E_alu_A    = rs_fwd;
    E_rt_fwd   = rt_fwd;
    E_alu_B    = ex_q.alu_src ? ex_q.ext_imm : rt_fwd;
    E_ALUCtrl  = ex_q.alu_ctrl;
    E_wa       = ex_q.wa;
    E_regwrite = ex_q.regwrite;
    E_memwrite = ex_q.memwrite;
    E_memtoreg = ex_q.memtoreg;
    E_rs_addr  = ex_q.rs_addr;
    E_rt_addr  = ex_q.rt_addr;
    E_tnew     = tnew_dec(ex_q.tnew);
    E_valid    = ex_q.valid;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, directly upstream of the EX-stage ALU.
- Captures decoded operands and control from ID each cycle, inserts bubbles on hazard stall, and tracks the destination register's remaining Tnew.
- Applies M/W forwarding and the ALUSrc select so it drives the ALU operand inputs and the store-data path.

Parameters:
- RESET_PC, 32'h0000_3000, PC value held by the register after reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit request: load a bubble instead of ID contents
- D_pc  in  32  PC of the instruction in ID
- D_rs_data  in  32  GRF rs read value, already forwarded in ID
- D_rt_data  in  32  GRF rt read value, already forwarded in ID
- D_ext_imm  in  32  extended immediate
- D_rs_addr  in  5  rs index
- D_rt_addr  in  5  rt index
- D_wa  in  5  destination register; 0 means no write
- D_ALUCtrl  in  3  ALU op code from the shared constants file
- D_ALUSrc  in  1  1 = immediate is ALU operand B
- D_regwrite  in  1  instruction writes the GRF
- D_memwrite  in  1  store
- D_memtoreg  in  1  load
- D_tnew  in  2  cycles until the result is produced, counted from ID
- M_fwd_we  in  1  M-stage result valid for forwarding (already Tnew-qualified)
- M_fwd_addr  in  5  M-stage destination
- M_fwd_data  in  32  M-stage result
- W_fwd_we  in  1  W-stage write enable
- W_fwd_addr  in  5  W-stage destination
- W_fwd_data  in  32  W-stage write data
- E_pc  out  32  registered PC
- E_alu_A  out  32  forwarded rs value, to ALU input A
- E_alu_B  out  32  forwarded rt value, or immediate when ALUSrc = 1
- E_rt_fwd  out  32  forwarded rt value, used as store data
- E_ALUCtrl  out  3  registered ALU op code
- E_wa  out  5  registered destination register
- E_regwrite  out  1  registered GRF write enable
- E_memwrite  out  1  registered store flag
- E_memtoreg  out  1  registered load flag
- E_rs_addr  out  5  registered rs index
- E_rt_addr  out  5  registered rt index
- E_tnew  out  2  remaining Tnew, for the hazard unit
- E_valid  out  1  0 = bubble

Behaviour:
- Register update on every rising clk edge. Priority: reset, then stall, then normal load.
- Reset: all registered fields 0, E_pc = RESET_PC, E_valid = 0. Combinational outputs follow from the zeroed fields (E_alu_A = 0 etc. unless forwarding hits; addr 0 never forwards).
- stall = 1 (bubble):
  - All control fields, data fields, addresses and tnew are cleared; E_valid = 0.
  - E_pc = D_pc, kept for later exception support.
  - A bubble never writes (regwrite = 0, wa = 0).
- Normal: every D_* field is captured; E_valid = 1. There is no hold mode; ID freezing is done by the IF/ID register.
- Tnew:
  - The stored tnew is D_tnew as it stood in ID.
  - E_tnew = stored - 1, saturating at 0.
  - Examples: D_tnew = 2 (load) gives E_tnew = 1; D_tnew = 0 gives E_tnew = 0.
- Forwarding (combinational, per source field rs and rt):
  - If addr != 0, M_fwd_we = 1 and M_fwd_addr == addr, use M_fwd_data.
  - Else if addr != 0, W_fwd_we = 1 and W_fwd_addr == addr, use W_fwd_data.
  - Else use the registered data.
  - M has priority over W when both match.
- Operand outputs:
  - E_alu_A = forwarded rs.
  - E_rt_fwd = forwarded rt.
  - E_alu_B = ALUSrc ? registered ext_imm : forwarded rt.
- Latency: one cycle from D_* to E_* registered fields. Forwarding adds zero cycles.
- Reset asserted together with stall: reset wins.
- A bubble in ID/EX has addr fields = 0, so it never matches a forward.

Decomposition:
- The shared constants file holds the ALU op codes (add, sub, ori, lui) and RESET_PC.
- One natural sub-module: fwd_mux. Inputs: addr, registered data, M/W forwarding triple. Output: selected 32-bit value. Instantiated twice, for rs and rt.

Test Plan:
- Reset: reset = 1 for 2 cycles with D_regwrite = 1 -> E_pc = 0x00003000, E_regwrite = 0, E_valid = 0, E_tnew = 0.
- Normal capture, addu: D_rs_data = 5, D_rt_data = 7, ALUSrc = 0, D_wa = 8, D_tnew = 1 -> next cycle E_alu_A = 5, E_alu_B = 7, E_wa = 8, E_tnew = 0, E_valid = 1.
- Immediate path, ori: ALUSrc = 1, D_ext_imm = 0x0000ABCD, D_rt_data = 0x1234 -> E_alu_B = 0x0000ABCD and E_rt_fwd = 0x1234.
- Forward priority: registered rs = 3, rs_addr = 9; M_fwd (we = 1, addr 9, 0x11) and W_fwd (we = 1, addr 9, 0x22) -> E_alu_A = 0x11. Drop M_fwd_we -> 0x22. Set rs_addr = 0 with both matching addr 0 -> E_alu_A = 0.
- Stall bubble: lw in ID (D_tnew = 2, regwrite = 1, D_pc = 0x3010), stall = 1 -> E_regwrite = 0, E_wa = 0, E_tnew = 0, E_pc = 0x3010, E_valid = 0. Next cycle stall = 0 -> E_tnew = 1, E_memtoreg = 1.
- Simultaneous: reset = 1 and stall = 1 with D_pc = 0x3020 -> E_pc = 0x00003000.
